// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-priority or
// round-robin arbitration and a valid/ready output handshake.
module prio_encoder_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] w,
   input  logic         en,
   input  logic         mode,
   output logic [W-1:0] y,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] ptr
);

   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic           valid_q, valid_d;
   logic           tag_q, tag_d;
   logic           cap, acc;
   logic [W-1:0]   fix_idx, rr_idx, off;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     sum;

   assign acc = valid_q && ready;
   assign cap = en && (!valid_q || ready);

   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (w[i]) fix_idx = W'(i);
      end
   end

   // Rotate so bit 0 is the request at ptr; lowest set bit wins.
   always_comb begin
      dbl = {w, w} >> ptr_q;
      rot = dbl[N-1:0];
      off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = W'(k);
      end
      sum = {1'b0, ptr_q} + {1'b0, off};
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      rr_idx = sum[W-1:0];
   end

   always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      ptr_d   = ptr_q;
      if (acc && tag_q) begin
         ptr_d = (y_q == W'(N - 1)) ? '0 : y_q + W'(1);
      end
      if (cap) begin
         if (|w) begin
            y_d     = mode ? rr_idx : fix_idx;
            valid_d = 1'b1;
            tag_d   = mode;
         end else begin
            valid_d = 1'b0;
         end
      end else if (acc) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q     <= '0;
         valid_q <= 1'b0;
         tag_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         ptr_q   <= ptr_d;
      end
   end

   assign y     = y_q;
   assign valid = valid_q;
   assign ptr   = ptr_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr at N=8, N=4 and N=6.
module tb_prio_encoder_rr;

   typedef struct {
      int y;
      int p;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   exp_t qA[$];
   exp_t qB[$];
   exp_t qC[$];

   logic       rstA, enA, modeA, rdyA, vA;
   logic [7:0] wA;
   logic [2:0] yA, pA;

   logic       rstB, enB, modeB, rdyB, vB;
   logic [3:0] wB;
   logic [1:0] yB, pB;

   logic       rstC, enC, modeC, rdyC, vC;
   logic [5:0] wC;
   logic [2:0] yC, pC;

   prio_encoder_rr #(.N(8)) dutA (
      .clk(clk), .reset(rstA), .w(wA), .en(enA), .mode(modeA),
      .y(yA), .valid(vA), .ready(rdyA), .ptr(pA)
   );

   prio_encoder_rr #(.N(4)) dutB (
      .clk(clk), .reset(rstB), .w(wB), .en(enB), .mode(modeB),
      .y(yB), .valid(vB), .ready(rdyB), .ptr(pB)
   );

   prio_encoder_rr #(.N(6)) dutC (
      .clk(clk), .reset(rstC), .w(wC), .en(enC), .mode(modeC),
      .y(yC), .valid(vC), .ready(rdyC), .ptr(pC)
   );

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int y, input int p);
      exp_t e;
      e.y = y;
      e.p = p;
      return e;
   endfunction

   // Monitors: compare each handshaken result against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rstA && vA && rdyA) begin
         if (qA.size() == 0) chk("A_unexpected_out", 1, 0);
         else begin
            e = qA.pop_front();
            chk("A_y", int'(yA), e.y);
            chk("A_ptr", int'(pA), e.p);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rstB && vB && rdyB) begin
         if (qB.size() == 0) chk("B_unexpected_out", 1, 0);
         else begin
            e = qB.pop_front();
            chk("B_y", int'(yB), e.y);
            chk("B_ptr", int'(pB), e.p);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rstC && vC && rdyC) begin
         if (qC.size() == 0) chk("C_unexpected_out", 1, 0);
         else begin
            e = qC.pop_front();
            chk("C_y", int'(yC), e.y);
            chk("C_ptr", int'(pC), e.p);
         end
         chk("C_ptr_range", int'(pC < 3'd6), 1);
      end
   end

   initial begin
      rstA = 1; enA = 0; modeA = 0; rdyA = 0; wA = '0;
      rstB = 1; enB = 0; modeB = 0; rdyB = 0; wB = '0;
      rstC = 1; enC = 0; modeC = 0; rdyC = 0; wC = '0;
      cyc();
      cyc();
      rstA = 0; rstB = 0; rstC = 0;
      chk("A_rst_y", int'(yA), 0);
      chk("A_rst_valid", int'(vA), 0);
      chk("A_rst_ptr", int'(pA), 0);
      chk("B_rst_ptr", int'(pB), 0);
      chk("C_rst_ptr", int'(pC), 0);

      // Fixed priority, then empty capture keeps y
      modeA = 0; enA = 1; rdyA = 1; wA = 8'b0010_0110;
      qA.push_back(mk(5, 0));
      cyc();
      chk("A_t1_valid", int'(vA), 1);
      wA = '0;
      cyc();
      chk("A_t1_empty_valid", int'(vA), 0);
      chk("A_t1_empty_y", int'(yA), 5);

      // Backpressure holds data, then accept+capture same cycle
      wA = 8'h80; enA = 1; rdyA = 1;
      qA.push_back(mk(7, 0));
      cyc();
      rdyA = 0; wA = 8'h01; enA = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("A_bp_hold_y", int'(yA), 7);
         chk("A_bp_hold_valid", int'(vA), 1);
      end
      rdyA = 1;
      qA.push_back(mk(0, 0));
      cyc();
      chk("A_bp_next_y", int'(yA), 0);
      enA = 0;
      cyc();
      chk("A_bp_drained", int'(vA), 0);

      // Reset mid-operation
      modeA = 1; wA = 8'h04; enA = 1; rdyA = 1;
      qA.push_back(mk(2, 0));
      cyc();
      enA = 0;
      cyc();
      chk("A_ptr_after_rr", int'(pA), 3);
      modeA = 0; wA = 8'h40; enA = 1; rdyA = 0;
      cyc();
      chk("A_pre_rst_y", int'(yA), 6);
      chk("A_pre_rst_valid", int'(vA), 1);
      rstA = 1; wA = 8'hFF; enA = 1;
      cyc();
      rstA = 0; enA = 0;
      chk("A_mid_rst_y", int'(yA), 0);
      chk("A_mid_rst_valid", int'(vA), 0);
      chk("A_mid_rst_ptr", int'(pA), 0);

      // Round-robin fairness and wrap, N=4
      modeB = 1; wB = 4'hF; rdyB = 1;
      for (int k = 0; k < 5; k++) begin
         enB = 1;
         qB.push_back(mk(k % 4, k % 4));
         cyc();
         enB = 0;
         cyc();
      end
      chk("B_ptr_wrap", int'(pB), 1);

      // Mode mix: fixed result leaves ptr alone
      modeB = 1; wB = 4'b0010; enB = 1;
      qB.push_back(mk(1, 1));
      cyc();
      enB = 0;
      cyc();
      chk("B_ptr_is_2", int'(pB), 2);
      modeB = 0; wB = 4'b1000; enB = 1;
      qB.push_back(mk(3, 2));
      cyc();
      enB = 0;
      cyc();
      chk("B_fixed_keeps_ptr", int'(pB), 2);
      modeB = 1; wB = 4'b0011; enB = 1;
      qB.push_back(mk(0, 2));
      cyc();
      enB = 0;
      cyc();
      chk("B_rr_ptr_after", int'(pB), 1);

      // Back-to-back: capture uses ptr before same-edge accept update
      modeB = 1; wB = 4'hF; enB = 1;
      qB.push_back(mk(1, 1));
      qB.push_back(mk(1, 2));
      qB.push_back(mk(2, 2));
      qB.push_back(mk(2, 3));
      repeat (4) cyc();
      enB = 0;
      cyc();
      chk("B_b2b_ptr", int'(pB), 3);

      // Non-power-of-2 wrap, N=6
      modeC = 1; wC = 6'b100001; rdyC = 1;
      for (int k = 0; k < 4; k++) begin
         enC = 1;
         qC.push_back(mk((k % 2 == 0) ? 0 : 5, (k % 2 == 0) ? 0 : 1));
         cyc();
         enC = 0;
         cyc();
         chk("C_ptr_after", int'(pC), (k % 2 == 0) ? 1 : 0);
      end

      repeat (3) cyc();
      chk("A_queue_empty", qA.size(), 0);
      chk("B_queue_empty", qB.size(), 0);
      chk("C_queue_empty", qC.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
